kalman_update_sequencer: RTL and testbench
==========================================

# kalman_update_sequencer

Control FSM for the scalar Kalman filter update datapath. A period counter fires one update every PERIOD clocks. For each update the block issues one-cycle step strobes to the datapath and runs the AXI-Stream exchange with the external divider IP. It sends dividend (gain numerator) and divisor (gain denominator), captures the quotient as the Kalman gain, and guards the divider wait with a timeout. It sits between the filter arithmetic and the divider and owns all update scheduling.

## Interface
- PERIOD, 1024, clocks between update ticks; legal range 10..2^COUNT_WIDTH-1
- COUNT_WIDTH, 32, period counter width
- DATA_WIDTH, 32, width of numerator, denominator and quotient
- DIV_TIMEOUT, 64, max cycles from DIV_REQ entry to quotient handshake; ≥2
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run period counter; low holds counter at 0
- err_clr  in  1  clears overrun and timeout_err
- num_in  in  DATA_WIDTH  gain numerator from datapath
- denom_in  in  DATA_WIDTH  gain denominator from datapath
- M_AXIS_OUT_DIVIDEND_tdata / _tvalid  out  DATA_WIDTH / 1; _tready  in  1
- M_AXIS_OUT_DIVISOR_tdata / _tvalid  out  DATA_WIDTH / 1; _tready  in  1
- S_AXIS_IN_kal_tdata  in  DATA_WIDTH  quotient; _tvalid in 1; _tready out 1
- gain  out  DATA_WIDTH  last captured quotient
- sample_en, predict_en, gain_en, state_en, var_en, commit_en  out  1 each  one-cycle step strobes
- busy  out  1  FSM not IDLE
- overrun  out  1  sticky: tick arrived while busy
- timeout_err  out  1  sticky: divider timeout abort
- update_count  out  16  committed updates, wraps at 2^16

## Operation
- States: IDLE, SAMPLE, PREDICT, DIV_REQ, DIV_WAIT, GAIN, STATE, VAR, COMMIT. Strobes are Moore outputs: each strobe is high only in its matching state.
- Tick: enable high and period counter == PERIOD-1. The counter then wraps to 0.
- Tick in IDLE → SAMPLE → PREDICT → DIV_REQ.
- Tick in any other state: the tick is dropped and overrun is set.
- DIV_REQ entry: register num_in and denom_in into the two tdata outputs, and raise both tvalids.
- Each tvalid falls the cycle after its own tready is seen. tdata is stable while tvalid is high.
- Leave DIV_REQ for DIV_WAIT once both streams have been accepted. They may be accepted in the same cycle or in different cycles.
- DIV_WAIT: S_AXIS_IN_kal_tready is high. It is low in all other states, so a quotient arriving early is not consumed.
- On the quotient handshake: latch gain, then go to GAIN → STATE → VAR → COMMIT → IDLE.
- COMMIT increments update_count.
- Timeout: the timer clears on DIV_REQ entry and counts every cycle in DIV_REQ and DIV_WAIT. On the cycle timer == DIV_TIMEOUT-1 without a quotient handshake, the block aborts:
  - both dividend/divisor tvalids drop next cycle; this is the only permitted AXIS hold exception;
  - timeout_err is set and the FSM returns to IDLE;
  - no GAIN through COMMIT strobes fire, and gain is unchanged.
- Quotient handshake in the same cycle as timer expiry: the handshake wins and no error is raised.
- enable low mid-update: the current update completes and no new ticks occur.
- err_clr and a new set event in the same cycle: set wins.

## Timing
- Reset values: FSM in IDLE, counter 0, all tvalids 0, S_AXIS_IN_kal_tready 0, tdata 0, gain 0, all strobes 0, busy 0, overrun 0, timeout_err 0, update_count 0.
- Tick at cycle T, zero-wait divider: sample_en at T+1, predict_en at T+2, DIV_REQ at T+3 with tvalids high. With tready high, DIV_WAIT at T+4; with quotient at T+4, gain_en at T+5, state_en at T+6, var_en at T+7, commit_en at T+8, IDLE at T+9.
- Every cycle of tready or quotient stall adds exactly one cycle to all later strobes.
- gain is valid from gain_en onward and holds until the next capture.
- PERIOD ≥ 10 guarantees no overrun with a zero-wait divider.

## Configuration
- KALMAN_SEQ_TIMEOUT_EN defined: the timeout logic above is built.
- Not defined: no timer; the FSM waits in DIV_REQ and DIV_WAIT indefinitely; timeout_err is tied to 0; DIV_TIMEOUT is ignored.

## Test plan
- PERIOD=16, readies tied high, quotient returned the cycle tready rises → strobes at T+1..T+8 exactly; update_count=3 after three ticks; overrun=0.
- Divisor tready delayed 3 cycles, dividend immediate → dividend tvalid drops at T+4, divisor tvalid holds until its handshake, commit_en at T+11.
- Quotient 0x00C0_0000 delivered after 5 cycles in DIV_WAIT → gain=0x00C0_0000 on the gain_en cycle; commit_en follows 3 cycles later.
- Quotient withheld, DIV_TIMEOUT=8, macro defined → tvalids drop, timeout_err=1, FSM IDLE, no commit_en, update_count unchanged, gain unchanged; err_clr clears the flag.
- PERIOD=10, divider stalled 4 cycles → next tick lands while busy: overrun=1, tick dropped, in-flight update still commits.
- rst asserted during DIV_WAIT → next cycle all outputs are at reset values; a quotient presented afterwards is not consumed (S_AXIS_IN_kal_tready=0).

Source files
------------

// File: rtl/kalman_update_sequencer.sv
// kalman_update_sequencer: schedules one scalar Kalman update every PERIOD
// clocks. It issues one-cycle step strobes to the datapath and runs the
// AXI-Stream exchange with the external divider that produces the gain.
// Optional feature macro: KALMAN_SEQ_TIMEOUT_EN. When it is defined, a
// divider wait longer than DIV_TIMEOUT cycles aborts the update.
module kalman_update_sequencer #(
  parameter int PERIOD      = 1024,
  parameter int COUNT_WIDTH = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  err_clr,
  input  logic [DATA_WIDTH-1:0] num_in,
  input  logic [DATA_WIDTH-1:0] denom_in,
  output logic [DATA_WIDTH-1:0] M_AXIS_OUT_DIVIDEND_tdata,
  output logic                  M_AXIS_OUT_DIVIDEND_tvalid,
  input  logic                  M_AXIS_OUT_DIVIDEND_tready,
  output logic [DATA_WIDTH-1:0] M_AXIS_OUT_DIVISOR_tdata,
  output logic                  M_AXIS_OUT_DIVISOR_tvalid,
  input  logic                  M_AXIS_OUT_DIVISOR_tready,
  input  logic [DATA_WIDTH-1:0] S_AXIS_IN_kal_tdata,
  input  logic                  S_AXIS_IN_kal_tvalid,
  output logic                  S_AXIS_IN_kal_tready,
  output logic [DATA_WIDTH-1:0] gain,
  output logic                  sample_en,
  output logic                  predict_en,
  output logic                  gain_en,
  output logic                  state_en,
  output logic                  var_en,
  output logic                  commit_en,
  output logic                  busy,
  output logic                  overrun,
  output logic                  timeout_err,
  output logic [15:0]           update_count
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_SAMPLE, ST_PREDICT, ST_DIV_REQ, ST_DIV_WAIT,
    ST_GAIN, ST_STATE, ST_VAR, ST_COMMIT
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] PERIOD_LAST = COUNT_WIDTH'(PERIOD - 1);

  state_t                 state;
  logic [COUNT_WIDTH-1:0] cnt;
  logic                   tick;
  logic                   dividend_hs;
  logic                   divisor_hs;
  logic                   quot_hs;
  logic                   dividend_done;
  logic                   divisor_done;
  logic                   both_done;

  assign tick        = enable && (cnt == PERIOD_LAST);
  assign dividend_hs = M_AXIS_OUT_DIVIDEND_tvalid && M_AXIS_OUT_DIVIDEND_tready;
  assign divisor_hs  = M_AXIS_OUT_DIVISOR_tvalid && M_AXIS_OUT_DIVISOR_tready;
  assign quot_hs     = S_AXIS_IN_kal_tready && S_AXIS_IN_kal_tvalid;
  // A stream counts as accepted if it handshook earlier or is handshaking now.
  assign both_done   = (dividend_done || dividend_hs) && (divisor_done || divisor_hs);

  // Period counter: free-runs while enabled, held at zero otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + COUNT_WIDTH'(1);
    end
  end

`ifdef KALMAN_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(DIV_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(DIV_TIMEOUT - 1);

  logic [TW-1:0] timer;
  logic          expire;

  // A quotient arriving on the last allowed cycle still counts as in time.
  assign expire = ((state == ST_DIV_REQ) || (state == ST_DIV_WAIT)) &&
                  (timer == TIMER_LAST) && !quot_hs;

  // Divider wait timer: zeroed on DIV_REQ entry, counts through the wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (state == ST_PREDICT) begin
      timer <= '0;
    end else if ((state == ST_DIV_REQ) || (state == ST_DIV_WAIT)) begin
      timer <= timer + TW'(1);
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  // Update sequencer: state, strobes, AXIS handshakes, gain and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                      <= ST_IDLE;
      M_AXIS_OUT_DIVIDEND_tdata  <= '0;
      M_AXIS_OUT_DIVIDEND_tvalid <= 1'b0;
      M_AXIS_OUT_DIVISOR_tdata   <= '0;
      M_AXIS_OUT_DIVISOR_tvalid  <= 1'b0;
      S_AXIS_IN_kal_tready       <= 1'b0;
      dividend_done              <= 1'b0;
      divisor_done               <= 1'b0;
      gain                       <= '0;
      sample_en                  <= 1'b0;
      predict_en                 <= 1'b0;
      gain_en                    <= 1'b0;
      state_en                   <= 1'b0;
      var_en                     <= 1'b0;
      commit_en                  <= 1'b0;
      busy                       <= 1'b0;
      overrun                    <= 1'b0;
`ifdef KALMAN_SEQ_TIMEOUT_EN
      timeout_err                <= 1'b0;
`endif
      update_count               <= '0;
    end else begin
      sample_en  <= 1'b0;
      predict_en <= 1'b0;
      gain_en    <= 1'b0;
      state_en   <= 1'b0;
      var_en     <= 1'b0;
      commit_en  <= 1'b0;

      // Clears come first so a same-cycle set below takes precedence.
      if (err_clr) begin
        overrun     <= 1'b0;
`ifdef KALMAN_SEQ_TIMEOUT_EN
        timeout_err <= 1'b0;
`endif
      end
      if (tick && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end

      // Each request tvalid falls independently after its own handshake.
      if (dividend_hs) begin
        M_AXIS_OUT_DIVIDEND_tvalid <= 1'b0;
      end
      if (divisor_hs) begin
        M_AXIS_OUT_DIVISOR_tvalid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (tick) begin
            state     <= ST_SAMPLE;
            sample_en <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_SAMPLE: begin
          state      <= ST_PREDICT;
          predict_en <= 1'b1;
        end
        ST_PREDICT: begin
          state                      <= ST_DIV_REQ;
          M_AXIS_OUT_DIVIDEND_tdata  <= num_in;
          M_AXIS_OUT_DIVISOR_tdata   <= denom_in;
          M_AXIS_OUT_DIVIDEND_tvalid <= 1'b1;
          M_AXIS_OUT_DIVISOR_tvalid  <= 1'b1;
          dividend_done              <= 1'b0;
          divisor_done               <= 1'b0;
        end
        ST_DIV_REQ: begin
          if (dividend_hs) begin
            dividend_done <= 1'b1;
          end
          if (divisor_hs) begin
            divisor_done <= 1'b1;
          end
          if (both_done) begin
            state                <= ST_DIV_WAIT;
            S_AXIS_IN_kal_tready <= 1'b1;
          end
        end
        ST_DIV_WAIT: begin
          if (quot_hs) begin
            gain                 <= S_AXIS_IN_kal_tdata;
            S_AXIS_IN_kal_tready <= 1'b0;
            state                <= ST_GAIN;
            gain_en              <= 1'b1;
          end
        end
        ST_GAIN: begin
          state    <= ST_STATE;
          state_en <= 1'b1;
        end
        ST_STATE: begin
          state  <= ST_VAR;
          var_en <= 1'b1;
        end
        ST_VAR: begin
          state     <= ST_COMMIT;
          commit_en <= 1'b1;
        end
        ST_COMMIT: begin
          state        <= ST_IDLE;
          busy         <= 1'b0;
          update_count <= update_count + 16'd1;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase

`ifdef KALMAN_SEQ_TIMEOUT_EN
      // Abort overrides anything the case chose this cycle, including a
      // same-cycle request acceptance; the request tvalids are withdrawn.
      if (expire) begin
        state                      <= ST_IDLE;
        busy                       <= 1'b0;
        M_AXIS_OUT_DIVIDEND_tvalid <= 1'b0;
        M_AXIS_OUT_DIVISOR_tvalid  <= 1'b0;
        S_AXIS_IN_kal_tready       <= 1'b0;
        timeout_err                <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_kalman_update_sequencer.sv
// Self-checking bench for kalman_update_sequencer (PERIOD=10, DIV_TIMEOUT=8).
// Table rows cover divider ready/quotient stall patterns; hand sequences
// cover back-to-back ticks, overrun, timeout abort and reset mid-update.
module tb_kalman_update_sequencer;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        err_clr;
  logic [31:0] num_in;
  logic [31:0] denom_in;
  logic [31:0] dvd_tdata;
  logic        dvd_tvalid;
  logic        dvd_tready;
  logic [31:0] dvs_tdata;
  logic        dvs_tvalid;
  logic        dvs_tready;
  logic [31:0] kal_tdata;
  logic        kal_tvalid;
  logic        kal_tready;
  logic [31:0] gain;
  logic        sample_en, predict_en, gain_en, state_en, var_en, commit_en;
  logic        busy, overrun, timeout_err;
  logic [15:0] update_count;

  int checks = 0;
  int errors = 0;

  kalman_update_sequencer #(
    .PERIOD(10), .COUNT_WIDTH(16), .DATA_WIDTH(32), .DIV_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .err_clr(err_clr),
    .num_in(num_in), .denom_in(denom_in),
    .M_AXIS_OUT_DIVIDEND_tdata(dvd_tdata),
    .M_AXIS_OUT_DIVIDEND_tvalid(dvd_tvalid),
    .M_AXIS_OUT_DIVIDEND_tready(dvd_tready),
    .M_AXIS_OUT_DIVISOR_tdata(dvs_tdata),
    .M_AXIS_OUT_DIVISOR_tvalid(dvs_tvalid),
    .M_AXIS_OUT_DIVISOR_tready(dvs_tready),
    .S_AXIS_IN_kal_tdata(kal_tdata),
    .S_AXIS_IN_kal_tvalid(kal_tvalid),
    .S_AXIS_IN_kal_tready(kal_tready),
    .gain(gain),
    .sample_en(sample_en), .predict_en(predict_en), .gain_en(gain_en),
    .state_en(state_en), .var_en(var_en), .commit_en(commit_en),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err),
    .update_count(update_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dd;          // dividend tready delay after DIV_REQ entry
    int          ds;          // divisor tready delay after DIV_REQ entry
    int          qd;          // quotient delay after DIV_WAIT entry
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] quot;
    int          dvd_fall;    // expected offsets from the tick cycle
    int          dvs_fall;
    int          gain_off;
    int          commit_off;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; enable = 1'b0; err_clr = 1'b0;
    dvd_tready = 1'b0; dvs_tready = 1'b0; kal_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_strobes"}, {26'd0, sample_en, predict_en, gain_en, state_en, var_en, commit_en}, 32'd0);
    check({tag, "_tvalids"}, {30'd0, dvd_tvalid, dvs_tvalid}, 32'd0);
    check({tag, "_kal_tready"}, {31'd0, kal_tready}, 32'd0);
    check({tag, "_dvd_tdata"}, dvd_tdata, 32'd0);
    check({tag, "_dvs_tdata"}, dvs_tdata, 32'd0);
    check({tag, "_gain"}, gain, 32'd0);
    check({tag, "_flags"}, {30'd0, overrun, timeout_err}, 32'd0);
    check({tag, "_update_count"}, {16'd0, update_count}, 32'd0);
  endtask

  // One update with the divider stall pattern of a table row.
  task automatic run_row(input int idx, input vec_t v);
    int rel, m, pulses;
    int f_s, f_p, f_g, f_st, f_v, f_c, fall_dvd, fall_dvs;
    logic got, busy_after;
    logic [1:0] req_v;
    logic [15:0] uc0;
    logic [31:0] d_dvd, d_dvs, g_seen;
    string tag;
    tag = $sformatf("row%0d", idx);
    m = (v.dd > v.ds) ? v.dd : v.ds;
    f_s = -1; f_p = -1; f_g = -1; f_st = -1; f_v = -1; f_c = -1;
    fall_dvd = -1; fall_dvs = -1; pulses = 0; got = 1'b0; busy_after = 1'b1;
    req_v = 2'b00; d_dvd = '0; d_dvs = '0; g_seen = '0;
    uc0 = update_count;
    num_in = v.num; denom_in = v.den; kal_tdata = v.quot;
    @(posedge clk); #1 enable = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk); #1;
      rel = k - 9;
      if (rel >= 1) enable = 1'b0;
      dvd_tready = (rel >= 3 + v.dd);
      dvs_tready = (rel >= 3 + v.ds);
      kal_tvalid = !got && (rel >= 4 + m + v.qd);
      @(negedge clk);
      if (sample_en  && f_s  < 0) f_s  = rel;
      if (predict_en && f_p  < 0) f_p  = rel;
      if (gain_en    && f_g  < 0) begin f_g = rel; g_seen = gain; end
      if (state_en   && f_st < 0) f_st = rel;
      if (var_en     && f_v  < 0) f_v  = rel;
      if (commit_en  && f_c  < 0) f_c  = rel;
      pulses += int'(sample_en) + int'(predict_en) + int'(gain_en) +
                int'(state_en) + int'(var_en) + int'(commit_en);
      if (rel == 3) begin
        req_v = {dvd_tvalid, dvs_tvalid};
        d_dvd = dvd_tdata; d_dvs = dvs_tdata;
      end
      if (rel > 3 && !dvd_tvalid && fall_dvd < 0) fall_dvd = rel;
      if (rel > 3 && !dvs_tvalid && fall_dvs < 0) fall_dvs = rel;
      if (kal_tvalid && kal_tready) got = 1'b1;
      if (rel == v.commit_off + 1) busy_after = busy;
    end
    dvd_tready = 1'b0; dvs_tready = 1'b0; kal_tvalid = 1'b0;
    check({tag, "_sample_at"},  f_s,  32'd1);
    check({tag, "_predict_at"}, f_p,  32'd2);
    check({tag, "_gain_en_at"}, f_g,  v.gain_off);
    check({tag, "_state_at"},   f_st, v.gain_off + 1);
    check({tag, "_var_at"},     f_v,  v.gain_off + 2);
    check({tag, "_commit_at"},  f_c,  v.commit_off);
    check({tag, "_pulses"},     pulses, 32'd6);
    check({tag, "_req_valid"},  {30'd0, req_v}, 32'd3);
    check({tag, "_dvd_data"},   d_dvd, v.num);
    check({tag, "_dvs_data"},   d_dvs, v.den);
    check({tag, "_dvd_fall"},   fall_dvd, v.dvd_fall);
    check({tag, "_dvs_fall"},   fall_dvs, v.dvs_fall);
    check({tag, "_gain"},       g_seen, v.quot);
    check({tag, "_idle_after"}, {31'd0, busy_after}, 32'd0);
    check({tag, "_count"},      {16'd0, update_count}, {16'd0, uc0 + 16'd1});
    check({tag, "_overrun"},    {31'd0, overrun}, 32'd0);
    check({tag, "_timeout"},    {31'd0, timeout_err}, 32'd0);
  endtask

  initial begin
    int c_cnt, c_first, c_last, s_cnt, late, rel;
    logic ov19, ov20;
    logic [15:0] uc0;
    logic [31:0] g0;
    logic [2:0] s10, s11;
    logic te10, te11, r20, rdy5;

    tbl[0] = '{0, 0, 0, 32'h0000_1000, 32'h0000_2000, 32'h0080_0000, 4, 4, 5, 8};
    tbl[1] = '{0, 3, 0, 32'h1111_2222, 32'h3333_4444, 32'h0012_3456, 4, 7, 8, 11};
    tbl[2] = '{0, 0, 5, 32'h0000_0300, 32'h0000_0400, 32'h00C0_0000, 4, 4, 10, 13};
    tbl[3] = '{2, 1, 1, 32'hA5A5_0001, 32'h5A5A_0002, 32'h0001_0001, 6, 5, 8, 11};
    tbl[4] = '{1, 1, 2, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 5, 5, 8, 11};
    tbl[5] = '{0, 0, 6, 32'h0000_0007, 32'h0000_0009, 32'h0044_0000, 4, 4, 11, 14};

    num_in = '0; denom_in = '0; kal_tdata = '0;
    apply_reset();
    @(negedge clk);
    check_reset_vals("reset");

    for (int i = 0; i < 6; i++) run_row(i, tbl[i]);

    // Three consecutive ticks, zero-wait divider.
    uc0 = update_count; c_cnt = 0; c_first = -1; c_last = -1;
    kal_tdata = 32'h1234_5678; dvd_tready = 1'b1; dvs_tready = 1'b1; kal_tvalid = 1'b1;
    @(posedge clk); #1 enable = 1'b1;
    for (int k = 1; k <= 38; k++) begin
      @(posedge clk); #1;
      if (k >= 30) enable = 1'b0;
      @(negedge clk);
      if (commit_en) begin
        c_cnt++;
        if (c_first < 0) c_first = k;
        c_last = k;
      end
    end
    dvd_tready = 1'b0; dvs_tready = 1'b0; kal_tvalid = 1'b0;
    check("tri_commits", c_cnt, 32'd3);
    check("tri_first_commit", c_first, 32'd17);
    check("tri_last_commit", c_last, 32'd37);
    check("tri_count", {16'd0, update_count}, {16'd0, uc0 + 16'd3});
    check("tri_overrun", {31'd0, overrun}, 32'd0);
    check("tri_gain", gain, 32'h1234_5678);
    check("tri_idle", {31'd0, busy}, 32'd0);

    // Quotient stalled 4 cycles so the tick at T+10 lands while busy.
    uc0 = update_count; c_cnt = 0; c_first = -1; s_cnt = 0; ov19 = 1'b1; ov20 = 1'b0;
    kal_tdata = 32'h0055_0000; dvd_tready = 1'b1; dvs_tready = 1'b1;
    @(posedge clk); #1 enable = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      rel = k - 9;
      if (rel >= 11) enable = 1'b0;
      kal_tvalid = (c_first < 0) && (rel >= 8) && (rel <= 12);
      @(negedge clk);
      if (sample_en) s_cnt++;
      if (commit_en) begin c_cnt++; if (c_first < 0) c_first = rel; end
      if (rel == 10) ov19 = overrun;
      if (rel == 11) ov20 = overrun;
    end
    dvd_tready = 1'b0; dvs_tready = 1'b0; kal_tvalid = 1'b0;
    check("ovr_before", {31'd0, ov19}, 32'd0);
    check("ovr_set", {31'd0, ov20}, 32'd1);
    check("ovr_samples", s_cnt, 32'd1);
    check("ovr_commit_at", c_first, 32'd12);
    check("ovr_commits", c_cnt, 32'd1);
    check("ovr_count", {16'd0, update_count}, {16'd0, uc0 + 16'd1});
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    check("ovr_cleared", {31'd0, overrun}, 32'd0);

    // Divider never answers.
    uc0 = update_count; g0 = gain; late = 0;
    s10 = 3'b000; s11 = 3'b111; te10 = 1'b1; te11 = 1'b0; r20 = 1'b0;
    @(posedge clk); #1 enable = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk); #1;
      rel = k - 9;
      if (rel >= 1) enable = 1'b0;
      @(negedge clk);
      late += int'(gain_en) + int'(state_en) + int'(var_en) + int'(commit_en);
      if (rel == 10) begin s10 = {dvd_tvalid, dvs_tvalid, busy}; te10 = timeout_err; end
      if (rel == 11) begin s11 = {dvd_tvalid, dvs_tvalid, busy}; te11 = timeout_err; end
      if (rel == 20) r20 = busy;
    end
    check("to_late_strobes", late, 32'd0);
    check("to_gain_kept", gain, g0);
    check("to_count_kept", {16'd0, update_count}, {16'd0, uc0});
    check("to_before", {29'd0, s10}, 32'd7);
`ifdef KALMAN_SEQ_TIMEOUT_EN
    check("to_err_before", {31'd0, te10}, 32'd0);
    check("to_after", {29'd0, s11}, 32'd0);
    check("to_err_set", {31'd0, te11}, 32'd1);
    check("to_idle_later", {31'd0, r20}, 32'd0);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    check("to_err_cleared", {31'd0, timeout_err}, 32'd0);
`else
    check("to_still_waiting", {29'd0, s11}, 32'd7);
    check("to_still_busy", {31'd0, r20}, 32'd1);
    check("to_err_tied", {31'd0, timeout_err | te11}, 32'd0);
`endif

    // Reset while waiting for the quotient.
    apply_reset();
    rdy5 = 1'b0; late = 0; r20 = 1'b0;
    dvd_tready = 1'b1; dvs_tready = 1'b1;
    @(posedge clk); #1 enable = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      rel = k - 9;
      if (rel >= 1) enable = 1'b0;
      rst = (rel == 5);
      if (rel >= 6) begin kal_tvalid = 1'b1; kal_tdata = 32'hDEAD_BEEF; end
      @(negedge clk);
      if (rel == 5) rdy5 = kal_tready;
      if (rel == 6) check_reset_vals("rstwait");
      if (rel > 6) begin
        late += int'(gain_en);
        r20 = r20 | kal_tready;
      end
    end
    kal_tvalid = 1'b0;
    check("rst_wait_ready", {31'd0, rdy5}, 32'd1);
    check("rst_no_consume", {31'd0, r20}, 32'd0);
    check("rst_no_gain_en", late, 32'd0);
    check("rst_gain_zero", gain, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
